// File: rtl/fetch_ctrl.sv
// Multi-cycle instruction-fetch sequencer: owns the PC, runs a single-outstanding
// req/gnt/rvalid fetch and holds each instruction for decode. Option: FETCH_ALIGN_CHK_EN.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic [1:0]  npc_op,
   input  logic [25:0] d_ins26,
   input  logic [29:0] d_ext32,
   input  logic [31:0] jr_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ins,
   output logic [31:0] ins_pc,
   output logic        ins_valid,
   output logic        align_err
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_faddr;
   logic [31:0] r_ins;
   logic [31:0] r_ins_pc;
   logic        r_ins_valid;
   logic [31:0] w_npc;

   // Branch offset is relative to the held instruction itself (no delay slot).
   always_comb begin
      w_npc = r_ins_pc + 32'd4;
      case (npc_op)
         2'b01:   w_npc = r_ins_pc + {d_ext32, 2'b00};
         2'b10:   w_npc = {r_ins_pc[31:28], d_ins26, 2'b00};
         2'b11:   w_npc = jr_target;
         default: w_npc = r_ins_pc + 32'd4;
      endcase
   end

`ifdef FETCH_ALIGN_CHK_EN
   logic r_align_err;
   logic w_misalign;
   assign w_misalign = |w_npc[1:0];
   assign align_err  = r_align_err;
`else
   assign align_err  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_pc        <= RESET_PC;
         r_faddr     <= RESET_PC;
         r_ins       <= 32'd0;
         r_ins_pc    <= 32'd0;
         r_ins_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
         r_align_err <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: r_state <= S_REQ;
            S_REQ: if (imem_gnt) begin
               r_faddr <= r_pc;
               r_state <= S_WAIT;
            end
            S_WAIT: if (imem_rvalid) begin
               r_ins       <= imem_rdata;
               r_ins_pc    <= r_faddr;
               r_ins_valid <= 1'b1;
               r_state     <= S_HOLD;
            end
            S_HOLD: if (!stall) begin
               r_ins_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
               if (w_misalign) begin
                  r_align_err <= 1'b1;
                  r_state     <= S_HALT;
               end else begin
                  r_pc    <= w_npc;
                  r_state <= S_REQ;
               end
`else
               r_pc    <= w_npc & 32'hFFFF_FFFC;
               r_state <= S_REQ;
`endif
            end
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Request side decodes only registered state, never the memory inputs.
   assign imem_req  = (r_state == S_REQ);
   assign imem_addr = r_pc;
   assign ins       = r_ins;
   assign ins_pc    = r_ins_pc;
   assign ins_valid = r_ins_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed test-plan sequences, then random
// handshake timing against a transaction-level fetch model.
module tb_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic [1:0]  npc_op = 2'b00;
   logic [25:0] d_ins26 = '0;
   logic [29:0] d_ext32 = '0;
   logic [31:0] jr_target = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] ins;
   logic [31:0] ins_pc;
   logic        ins_valid;
   logic        align_err;

   fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .npc_op(npc_op),
      .d_ins26(d_ins26), .d_ext32(d_ext32), .jr_target(jr_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid), .align_err(align_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Transaction model: what the fetch unit should present after the coming edge.
   logic        exp_req, exp_iv, outst, exp_aerr;
   logic [31:0] exp_pc, fa, exp_ins, exp_ins_pc;

   logic [12:0] reqmask;
   logic [31:0] seen [0:12];
   logic        g, rv, st;
   logic [1:0]  op;
   logic [31:0] jr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [1:0] o,
                                           input logic [25:0] i26, input logic [29:0] e32,
                                           input logic [31:0] j);
      logic [31:0] off;
      off = {e32, 2'b00};
      case (o)
         2'd0: return pc + 32'd4;
         2'd1: return pc + off;
         2'd2: return {pc[31:28], i26, 2'b00};
         default: return j;
      endcase
   endfunction

   task automatic sample_chk();
      @(negedge clk);
      chk("req", imem_req, exp_req);
      if (exp_req) chk("addr", imem_addr, exp_pc);
      chk("ins_valid", ins_valid, exp_iv);
      if (exp_iv) begin
         chk("ins", ins, exp_ins);
         chk("ins_pc", ins_pc, exp_ins_pc);
      end
      chk("align_err", align_err, exp_aerr);
   endtask

   task automatic drive(input logic gi, input logic rvi, input logic [31:0] rd, input logic sti,
                        input logic [1:0] opi, input logic [25:0] i26, input logic [29:0] e32,
                        input logic [31:0] ji);
      logic [31:0] np;
      imem_gnt = gi; imem_rvalid = rvi; imem_rdata = rd; stall = sti;
      npc_op = opi; d_ins26 = i26; d_ext32 = e32; jr_target = ji;
      if (exp_iv && !sti) begin
         np = next_pc(exp_ins_pc, opi, i26, e32, ji);
         exp_iv = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
         if (np[1:0] != 2'b00) begin
            exp_aerr = 1'b1;
            exp_req  = 1'b0;
         end else begin
            exp_pc  = np;
            exp_req = 1'b1;
         end
`else
         exp_pc  = {np[31:2], 2'b00};
         exp_req = 1'b1;
`endif
      end else if (outst && rvi) begin
         outst = 1'b0; exp_iv = 1'b1; exp_ins = rd; exp_ins_pc = fa;
      end else if (exp_req && gi) begin
         exp_req = 1'b0; outst = 1'b1; fa = exp_pc;
      end
   endtask

   // Holds reset for one edge, checks reset values, then releases with a
   // spurious grant and optionally a stale response that must both be ignored.
   task automatic do_reset(input logic stale_rv);
      rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; stall = 1'b0;
      exp_req = 1'b0; exp_iv = 1'b0; outst = 1'b0; exp_aerr = 1'b0; exp_pc = RESET_PC;
      @(negedge clk);
      chk("rst_req", imem_req, 32'd0);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_ins", ins, 32'd0);
      chk("rst_ins_pc", ins_pc, 32'd0);
      chk("rst_iv", ins_valid, 32'd0);
      chk("rst_aerr", align_err, 32'd0);
      rst_n = 1'b1; imem_gnt = 1'b1; imem_rvalid = stale_rv; imem_rdata = 32'hDEAD_BEEF;
      exp_req = 1'b1;
   endtask

   initial begin
      do_reset(1'b0);

      // Zero-wait sequential fetch, then branch back at 0x3008 and jump at 0x3000.
      for (int k = 0; k < 13; k++) begin
         sample_chk();
         reqmask[k] = imem_req;
         seen[k]    = imem_addr;
         op = (k == 8) ? 2'd1 : ((k == 11) ? 2'd2 : 2'd0);
         drive(k != 12, 1'b1, 32'h1000_0000 + k, 1'b0, op, 26'h0000C10, 30'h3FFF_FFFE, 32'd0);
      end
      chk("zw_reqpat", {19'd0, reqmask}, 32'h0000_1249);
      chk("zw_a0", seen[0], 32'h3000);
      chk("zw_a1", seen[3], 32'h3004);
      chk("zw_a2", seen[6], 32'h3008);
      chk("branch", seen[9], 32'h3000);
      chk("jump", seen[12], 32'h3040);

      // Grant withheld for three cycles in total.
      for (int k = 0; k < 2; k++) begin
         sample_chk();
         chk("hs_req", imem_req, 32'd1);
         chk("hs_addr", imem_addr, 32'h3040);
         drive(1'b0, 1'b1, 32'h0, 1'b0, 2'd0, '0, '0, '0);
      end
      sample_chk();
      chk("hs_addr", imem_addr, 32'h3040);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 2'd0, '0, '0, '0);
      sample_chk();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, '0, '0, '0);
      sample_chk();
      drive(1'b0, 1'b1, 32'h2408_0005, 1'b1, 2'd0, '0, '0, '0);
      for (int k = 0; k < 4; k++) begin
         sample_chk();
         chk("st_ins", ins, 32'h2408_0005);
         chk("st_req", imem_req, 32'd0);
         drive(1'b1, 1'b1, 32'hBAD0_0000, k < 3, 2'd0, '0, '0, '0);
      end
      sample_chk();
      chk("st_iv_fall", ins_valid, 32'd0);
      chk("st_next", imem_addr, 32'h3044);

      // Reset while waiting for a response; the stale response must be dropped.
      drive(1'b1, 1'b0, 32'h0, 1'b0, 2'd0, '0, '0, '0);
      sample_chk();
      do_reset(1'b1);
      sample_chk();
      chk("rw_iv", ins_valid, 32'd0);
      chk("rw_addr", imem_addr, 32'h3000);

      // Misaligned register jump.
      drive(1'b1, 1'b0, 32'h0, 1'b0, 2'd0, '0, '0, '0);
      sample_chk();
      drive(1'b0, 1'b1, 32'h0000_0008, 1'b0, 2'd0, '0, '0, '0);
      sample_chk();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 2'd3, '0, '0, 32'h0000_3002);
      for (int k = 0; k < 3; k++) begin
         sample_chk();
`ifdef FETCH_ALIGN_CHK_EN
         chk("al_err", align_err, 32'd1);
         chk("al_req", imem_req, 32'd0);
`else
         if (k == 0) chk("al_addr", imem_addr, 32'h3000);
`endif
         drive(1'b1, 1'b1, 32'h0, 1'b0, 2'd0, '0, '0, '0);
      end
      sample_chk();
      do_reset(1'b0);

      // Random handshake timing, stalls and next-PC selects.
      for (int n = 0; n < 600; n++) begin
         sample_chk();
         if ($urandom % 128 == 0) begin
            do_reset(1'($urandom % 2));
         end else begin
            g  = exp_req ? ($urandom % 3 != 0) : ($urandom % 2 == 0);
            rv = outst ? ($urandom % 3 == 0) : ($urandom % 4 == 0);
            st = ($urandom % 3 == 0);
            op = 2'($urandom % 4);
            jr = $urandom;
`ifdef FETCH_ALIGN_CHK_EN
            jr[1:0] = 2'b00;
`endif
            drive(g, rv, $urandom, st, op, 26'($urandom), 30'($urandom), jr);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Multi-cycle instruction-fetch sequencer for the MIPS core. It owns the PC register and computes the next PC from the decode stage's npc_op, d_ins26 and d_ext32, using the same arithmetic as the next-PC unit. It drives a single-outstanding request/grant/response handshake to instruction memory. Each fetched instruction is held in an output register for decode until decode accepts it.

## Interface
- RESET_PC, 32'h0000_3000, fetch address after reset
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  decode cannot accept the presented instruction
- npc_op  in  2  next-PC select for the presented instruction
  - 00: pc+4
  - 01: pc+{d_ext32,2'b00}
  - 10: {pc[31:28],d_ins26,2'b00}
  - 11: jr_target
- d_ins26  in  26  jump index field
- d_ext32  in  30  sign-extended branch offset, low 30 bits
- jr_target  in  32  register jump target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  response instruction
- ins  out  32  held instruction
- ins_pc  out  32  address of held instruction
- ins_valid  out  1  ins/ins_pc valid
- align_err  out  1  misaligned target detected, sticky

## Operation
- State machine: IDLE, REQ, WAIT, HOLD, HALT.
- IDLE: entered on reset; PC = RESET_PC; goes to REQ next cycle.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_gnt, latch fetch address and go to WAIT; otherwise stay in REQ with req and addr stable.
- WAIT:
  - imem_req=0.
  - On imem_rvalid: ins<=imem_rdata, ins_pc<=fetch address, ins_valid<=1, go to HOLD.
- HOLD:
  - ins_valid=1; ins and ins_pc are stable while stall=1.
  - On stall=0 the instruction is consumed at that edge:
    - pc <= next_pc(ins_pc, npc_op, d_ins26, d_ext32, jr_target)
    - ins_valid <= 0; go to REQ.
- next_pc arithmetic:
  - 32-bit, wraps modulo 2^32.
  - The branch offset is added to ins_pc itself; no +4, no delay slot.
- imem_rvalid outside WAIT is ignored. imem_gnt outside REQ is ignored.
- HALT (only with the macro below): no requests, ins_valid=0, align_err=1. Leaves only on reset.
- Reset mid-operation (any state): at that edge the block returns to IDLE, pc=RESET_PC, ins_valid=0 and align_err=0. Any outstanding response is ignored because the block is no longer in WAIT.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC
  - ins=0, ins_pc=0, ins_valid=0, align_err=0
- imem_req and imem_addr are decoded from the registered state and pc; they have no combinational path from the memory inputs.
- Latency is one cycle per step with zero wait states:
  - REQ, granted same cycle
  - WAIT, rvalid
  - HOLD, consumed
  - Result: minimum 3 cycles per instruction.
- First request is asserted in the 2nd cycle after rst_n rises.
- npc_op, d_ins26, d_ext32 and jr_target are sampled only in the HOLD cycle where stall=0.
- ins_valid falls in the cycle after consumption.

## Configuration
- FETCH_ALIGN_CHK_EN
- Defined:
  - If the computed next_pc[1:0]!=0 at consumption, pc is not updated.
  - align_err<=1 and the state goes to HALT.
- Undefined:
  - next_pc[1:0] is forced to 2'b00 and fetch continues.
  - align_err is tied 0 and HALT is unreachable.

## Test plan
- Reset, zero-wait memory, npc_op=00, stall=0: imem_addr sequence 0x3000, 0x3004, 0x3008, with imem_req high every 3rd cycle starting 2 cycles after reset release.
- Branch: ins_pc=0x3008, npc_op=01, d_ext32=30'h3FFF_FFFE → next imem_addr=0x3000.
- Jump: ins_pc=0x3000, npc_op=10, d_ins26=26'h0000C10 → next imem_addr=0x0000_3040.
- Handshake and stall:
  - gnt withheld 3 cycles: imem_req and imem_addr stable throughout.
  - rvalid 2 cycles after gnt with rdata=0x2408_0005: ins=0x2408_0005 held while stall=1 for 4 cycles.
  - No new request until stall drops.
- Reset in WAIT: rst_n low 1 cycle, then stale rvalid: response ignored, ins_valid=0, next imem_addr=0x3000.
- npc_op=11, jr_target=0x0000_3002:
  - With FETCH_ALIGN_CHK_EN: align_err=1, imem_req stays 0.
  - Without it: next imem_addr=0x3000.
